// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI master: FSM state encodings,
//            byte / bit-counter widths and the debug word field layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int BYTE_W  = 8;   // bits per SPI transfer
  localparam int CNT_W   = 3;   // bit counter width (terminal count 7)
  localparam int STATE_W = 3;   // FSM state code width

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_HOLD   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  // Debug word: {1'b0, state[2:0], 1'b0, bit_count[2:0]}
  localparam int DBG_W         = 8;
  localparam int DBG_STATE_LSB = 4;
  localparam int DBG_CNT_LSB   = 0;

  function automatic logic [DBG_W-1:0] pack_debug(input state_t st,
                                                  input logic [CNT_W-1:0] cnt);
    logic [DBG_W-1:0] d;
    d = '0;
    d[DBG_STATE_LSB +: STATE_W] = st;
    d[DBG_CNT_LSB +: CNT_W]     = cnt;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clkgen
// Purpose  : Half-period tick generator. Counts system clocks and pulses
//            'tick' on the last cycle of every CLK_HALF_PERIOD-long phase.
//            'restart' holds the counter at zero so the first phase after
//            an untimed state is a full half period.
// Ports    : clk     - system clock
//            rst     - synchronous active-high reset
//            restart - hold counter at zero while asserted
//            tick    - last cycle of the current half period
// Revision : 1.0 - initial release
// ============================================================================
module spi_clkgen #(
  parameter int CLK_HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] C_TC = 8'(CLK_HALF_PERIOD - 1);

  logic [7:0] cnt;

  assign tick = (cnt == C_TC);

  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Byte-oriented SPI mode-0 master with ready/valid transmit side,
//            multi-byte transactions (SPI_SS held low between bytes until a
//            byte flagged txLast completes) and a guaranteed SS high gap.
// Ports    : SysClk, Reset         - clock, synchronous active-high reset
//            txData/txValid/txLast - byte to send, handshake, end-of-transaction
//            txReady               - byte accepted when txValid && txReady
//            rxData/rxValid        - received byte, one-cycle strobe
//            busy                  - high whenever the FSM is not IDLE
//            SPI_CLK/MOSI/MISO/SS  - SPI bus (SS active low)
//            debug_out             - {0,state,0,bit count}; only present when
//                                    SPI_MASTER_DEBUG_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_HALF_PERIOD = 2,
  parameter int SS_GAP          = 4
) (
  input  logic              SysClk,
  input  logic              Reset,
  input  logic [BYTE_W-1:0] txData,
  input  logic              txValid,
  input  logic              txLast,
  output logic              txReady,
  output logic [BYTE_W-1:0] rxData,
  output logic              rxValid,
  output logic              busy,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_SS
`ifdef SPI_MASTER_DEBUG_EN
  ,
  output logic [DBG_W-1:0]  debug_out
`endif
);

  localparam logic [7:0]       C_GAP_TC = 8'(SS_GAP - 1);
  localparam logic [CNT_W-1:0] C_BIT_TC = CNT_W'(BYTE_W - 1);

  state_t            state;
  logic [BYTE_W-1:0] tx_shift;
  logic [BYTE_W-1:0] rx_shift;
  logic              last_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        gap_cnt;
  logic              tick;
  logic              timed;
  logic              accept;

  // Only SETUP and the two clock phases are paced by the half-period counter;
  // every other state keeps it parked at zero.
  assign timed  = (state == ST_SETUP) || (state == ST_SCK_HI) || (state == ST_SCK_LO);
  assign accept = txValid && txReady;

  spi_clkgen #(
    .CLK_HALF_PERIOD(CLK_HALF_PERIOD)
  ) u_clkgen (
    .clk    (SysClk),
    .rst    (Reset),
    .restart(!timed),
    .tick   (tick)
  );

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      SPI_SS   <= 1'b1;
      SPI_CLK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      txReady  <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      last_q   <= 1'b0;
    end else begin
      rxValid <= 1'b0;
      case (state)
        // IDLE and HOLD share the accept path; they differ only in SS level,
        // which was already set when the state was entered.
        ST_IDLE, ST_HOLD: begin
          txReady <= 1'b1;
          if (accept) begin
            state    <= ST_SETUP;
            tx_shift <= txData;
            last_q   <= txLast;
            bit_cnt  <= '0;
            SPI_SS   <= 1'b0;
            SPI_MOSI <= txData[BYTE_W-1];
            txReady  <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (tick) begin
            state    <= ST_SCK_HI;
            SPI_CLK  <= 1'b1;
            rx_shift <= {rx_shift[BYTE_W-2:0], SPI_MISO};
          end
        end

        ST_SCK_HI: begin
          if (tick) begin
            state    <= ST_SCK_LO;
            SPI_CLK  <= 1'b0;
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            SPI_MOSI <= tx_shift[BYTE_W-2];
          end
        end

        ST_SCK_LO: begin
          if (tick) begin
            // Wraps 7 -> 0 after the last bit, so HOLD/GAP show a clean count.
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == C_BIT_TC) begin
              rxValid <= 1'b1;
              rxData  <= rx_shift;
              if (last_q) begin
                state   <= ST_GAP;
                SPI_SS  <= 1'b1;
                gap_cnt <= '0;
              end else begin
                state   <= ST_HOLD;
                txReady <= 1'b1;
              end
            end else begin
              state    <= ST_SCK_HI;
              SPI_CLK  <= 1'b1;
              rx_shift <= {rx_shift[BYTE_W-2:0], SPI_MISO};
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == C_GAP_TC) begin
            state   <= ST_IDLE;
            txReady <= 1'b1;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_DEBUG_EN
  // Built from registered state, so it reads zero straight out of reset.
  assign debug_out = pack_debug(state, bit_cnt);
`endif

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_HALF_PERIOD, default 2, SysClk cycles per SPI_CLK half period (legal range 1..255).
REQ-002 SHALL have parameter SS_GAP, default 4, minimum SysClk cycles SPI_SS stays high between transactions (legal range 1..255).
REQ-003 SHALL use one clock and a synchronous, active-high reset: SysClk in 1, the single clock; Reset in 1, synchronous active-high reset.
REQ-004 SHALL have port txData, input, 8 bits: byte to transmit, MSB first.
REQ-005 SHALL have port txValid, input, 1 bit: txData and txLast are valid.
REQ-006 SHALL have port txLast, input, 1 bit: this byte ends the transaction (SPI_SS is released after it).
REQ-007 SHALL have port txReady, output, 1 bit: byte accepted when txValid && txReady.
REQ-008 SHALL have port rxData, output, 8 bits: byte shifted in from SPI_MISO.
REQ-009 SHALL have port rxValid, output, 1 bit: one-cycle pulse; rxData is valid.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have ports SPI_CLK (output, 1), SPI_MOSI (output, 1), SPI_MISO (input, 1) and SPI_SS (output, 1, active-low).

Function
REQ-012 SHALL implement SPI mode 0: SPI_CLK idles low; SPI_MOSI changes only while SPI_CLK is low; SPI_MISO is sampled in the SysClk cycle SPI_CLK is driven high.
REQ-013 SHALL implement states IDLE, SETUP, SCK_HI, SCK_LO, HOLD and GAP.
REQ-014 IDLE: txReady=1, SPI_SS=1; on accept, latch txData and txLast, then next cycle drive SPI_SS=0 and SPI_MOSI=txData[7], and enter SETUP.
REQ-015 SETUP SHALL last CLK_HALF_PERIOD cycles, then go to SCK_HI.
REQ-016 SCK_HI: SPI_CLK=1 for CLK_HALF_PERIOD cycles; the MISO bit is shifted into the rx register LSB on entry; then go to SCK_LO.
REQ-017 SCK_LO: SPI_CLK=0 for CLK_HALF_PERIOD cycles; SPI_MOSI advances to the next bit on entry; after the 8th SCK_LO, rxValid pulses for 1 cycle with rxData = the 8 sampled bits.
REQ-018 After the 8th bit with latched txLast=0, the block SHALL enter HOLD: SPI_SS=0, SPI_CLK=0, txReady=1; it waits indefinitely; on accept it latches the new byte and enters SETUP.
REQ-019 After the 8th bit with latched txLast=1, the block SHALL drive SPI_SS=1 and enter GAP for SS_GAP cycles (txReady=0), then return to IDLE.
REQ-020 The bit counter SHALL be 3 bits, with the 8th-bit terminal count at 7, and SHALL reset to 0 on each byte accept.
REQ-021 txReady SHALL be 0 in SETUP, SCK_HI, SCK_LO and GAP; txValid in those states SHALL be ignored and SHALL NOT be lost by the source.
REQ-022 rxValid and the accept of the next byte in HOLD MAY coincide in the same cycle; both SHALL take effect.
REQ-023 Byte period with CLK_HALF_PERIOD=N SHALL be exactly 17*N SysClk cycles from accept to rxValid (setup plus 16 half periods), plus 1 cycle of latch latency.

Reset
REQ-024 Reset SHALL force the following, regardless of state: state=IDLE, SPI_SS=1, SPI_CLK=0, SPI_MOSI=0, rxData=0, rxValid=0, txReady=0 during reset and 1 the cycle after, busy=0, counters=0.
REQ-025 Reset asserted mid-byte SHALL discard the partial byte with no rxValid.

Configuration
REQ-026 With SPI_MASTER_DEBUG_EN defined, the block SHALL add output debug_out[7:0] = {1'b0, state code[2:0], 1'b0, bit count[2:0]}, reset to 0.
REQ-027 Without SPI_MASTER_DEBUG_EN, debug_out and its logic SHALL be absent.

Structure
REQ-028 Shared package spi_pkg SHALL hold the state encodings, the byte width (8) and the debug field layout constants.
REQ-029 Sub-module spi_clkgen SHALL provide the half-period tick counter (CLK_HALF_PERIOD terminal count, restart input); no other sub-modules.

Verification
REQ-030 Single byte: txData=0xA5 with txLast=1, slave model returns 0x3C -> SPI_MOSI samples 1,0,1,0,0,1,0,1 on rising edges; rxData=0x3C with one rxValid; SPI_SS high for at least 4 cycles afterwards.
REQ-031 Burst: 0x12 (txLast=0) then 0x34 (txLast=1) presented back-to-back -> SPI_SS stays low across both bytes; rxValid pulses twice; exactly 16 rising edges of SPI_CLK.
REQ-032 HOLD stall: second byte delayed 50 cycles -> SPI_SS low and SPI_CLK low throughout the delay; transfer resumes correctly.
REQ-033 Reset after 3 SPI_CLK rising edges -> SPI_SS=1 and SPI_CLK=0 the next cycle; no rxValid; next transaction is correct.
REQ-034 CLK_HALF_PERIOD=1 with MOSI looped to MISO, bytes 0x00, 0xFF, 0x80 -> rxData echoes each byte; rxValid exactly 17 cycles after each accept's latch cycle.
REQ-035 With SPI_MASTER_DEBUG_EN defined -> debug_out tracks state and bit count each cycle and reads 0 in IDLE after reset.
